// File: rtl/quarknet_readout_pkg.sv
// Shared types and constants for the tube timing bus readout.
// Frame length grows by one checksum byte when TUBE_READOUT_CSUM_EN is defined.
package quarknet_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    SELECT,
    SETTLE,
    CAPTURE,
    SEND
  } state_t;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] MISS_BYTE = 8'hFF;

  // Header and sequence bytes precede the per-channel time bytes.
  localparam int FRAME_OVERHEAD = 2;
`ifdef TUBE_READOUT_CSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  function automatic int frame_len(input int n_tubes);
    return FRAME_OVERHEAD + n_tubes + CSUM_BYTES;
  endfunction

endpackage

// File: rtl/tube_readout_ctrl_frame_tx.sv
// frame_tx: latches a complete event frame and streams it byte by byte on valid/ready.
// OUT_DATA is driven from the latched buffer, so it cannot change while a byte is stalled.
module frame_tx #(
  parameter int LEN = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic [LEN-1:0][7:0] frame,
  input  logic                OUT_READY,
  output logic [7:0]          OUT_DATA,
  output logic                OUT_VALID,
  output logic                done
);

  localparam int IW = $clog2(LEN);

  logic [LEN-1:0][7:0] frame_q;
  logic [IW-1:0]       idx;
  logic                xfer;
  logic                last;

  assign xfer     = OUT_VALID & OUT_READY;
  assign last     = (idx == IW'(LEN - 1));
  assign done     = xfer & last;
  assign OUT_DATA = OUT_VALID ? frame_q[idx] : 8'h00;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_q   <= '0;
      idx       <= '0;
      OUT_VALID <= 1'b0;
    end else if (load) begin
      frame_q   <= frame;
      idx       <= '0;
      OUT_VALID <= 1'b1;
    end else if (xfer) begin
      if (last) begin
        idx       <= '0;
        OUT_VALID <= 1'b0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/tube_readout_ctrl.sv
// Tube timing bus readout master: trigger, capture window, per-channel sampling, framed output.
// Optional checksum byte enabled by defining TUBE_READOUT_CSUM_EN.
module tube_readout_ctrl
  import quarknet_readout_pkg::*;
#(
  parameter int          N_TUBES  = 4,
  parameter int          WINDOW   = 255,
  parameter int          READ_LAT = 2,
  parameter int          TIMEOUT  = 16,
  parameter logic [7:0]  HDR      = HDR_BYTE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCIN_COINC,
  output logic [1:0] CHIP_SEL,
  input  logic [7:0] CHIP_DATA,
  input  logic       DATA_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       BUSY,
  output logic [7:0] EVT_COUNT,
  output logic [7:0] DROP_COUNT,
  output logic [3:0] MISS_FLAGS
);

  localparam int         LEN       = frame_len(N_TUBES);
  localparam int         CW        = 16;
  localparam logic [3:0] MISS_MASK = 4'((1 << N_TUBES) - 1);

  state_t              state, next_state;
  logic [CW-1:0]       cnt;
  logic [1:0]          ch;
  logic [1:0]          chip_sel_q;
  logic                coinc_prev;
  logic                armed;
  logic                trig;
  logic [7:0]          seq_q;
  logic [7:0]          evt_q;
  logic [7:0]          drop_q;
  logic [3:0]          miss_q;
  logic [N_TUBES-1:0][7:0] times_q;
  logic [7:0]          cap_byte;
  logic                last_ch;
  logic                chan_done;
  logic                load;
  logic                tx_done;
  logic [LEN-1:0][7:0] frame;
  logic [7:0]          csum;

  // armed stays low until SCIN_COINC is seen low, so a level held through reset cannot trigger.
  assign trig     = SCIN_COINC & ~coinc_prev & armed;
  assign cap_byte = DATA_READY ? CHIP_DATA : MISS_BYTE;
  assign last_ch  = (ch == 2'(N_TUBES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    chan_done  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE:     if (trig) next_state = (WINDOW == 0) ? SELECT : WAIT_WIN;
      WAIT_WIN: if (cnt == CW'(WINDOW - 1)) next_state = SELECT;
      SELECT:   next_state = (READ_LAT == 0) ? CAPTURE : SETTLE;
      SETTLE:   if (cnt == CW'(READ_LAT - 1)) next_state = CAPTURE;
      CAPTURE: begin
        if (DATA_READY || cnt == CW'(TIMEOUT - 1)) begin
          chan_done = 1'b1;
          if (last_ch) begin
            next_state = SEND;
            load       = 1'b1;
          end else begin
            next_state = SELECT;
          end
        end
      end
      SEND:     if (tx_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      ch         <= '0;
      chip_sel_q <= '0;
      coinc_prev <= 1'b0;
      armed      <= 1'b0;
      seq_q      <= '0;
      evt_q      <= '0;
      drop_q     <= '0;
      miss_q     <= '0;
      times_q    <= '0;
    end else begin
      coinc_prev <= SCIN_COINC;
      if (!SCIN_COINC) armed <= 1'b1;
      cnt <= (next_state != state) ? '0 : cnt + CW'(1);
      if (trig && state != IDLE && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (trig && state == IDLE) begin
        miss_q <= '0;
        seq_q  <= evt_q;
        ch     <= '0;
      end
      if (state == SELECT) chip_sel_q <= ch;
      if (chan_done) begin
        times_q[ch] <= cap_byte;
        if (!DATA_READY) miss_q[ch] <= 1'b1;
        ch <= last_ch ? 2'd0 : ch + 2'd1;
      end
      if (tx_done) evt_q <= evt_q + 8'd1;
    end
  end

  // The last channel's byte is still on the bus when the frame is loaded, so it is taken directly.
  always_comb begin
    frame    = '0;
    frame[0] = HDR;
    frame[1] = seq_q;
    for (int i = 0; i < N_TUBES; i++)
      frame[2+i] = (2'(i) == ch) ? cap_byte : times_q[i];
  end

`ifdef TUBE_READOUT_CSUM_EN
  always_comb begin
    csum = seq_q;
    for (int i = 0; i < N_TUBES; i++) csum = csum ^ frame[2+i];
  end
`else
  assign csum = 8'h00;
`endif

  logic [LEN-1:0][7:0] frame_full;

  always_comb begin
    frame_full = frame;
`ifdef TUBE_READOUT_CSUM_EN
    frame_full[LEN-1] = csum;
`endif
  end

  frame_tx #(.LEN(LEN)) u_frame_tx (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load),
    .frame     (frame_full),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .done      (tx_done)
  );

  assign BUSY       = (state != IDLE);
  assign CHIP_SEL   = chip_sel_q;
  assign EVT_COUNT  = evt_q;
  assign DROP_COUNT = drop_q;
  assign MISS_FLAGS = miss_q & MISS_MASK;

endmodule

// File: tb/tb_tube_readout_ctrl.sv
// Directed bench for tube_readout_ctrl with a simple tube chip model and stream monitor.
module tb_tube_readout_ctrl;

`ifdef TUBE_READOUT_CSUM_EN
  localparam int LEN     = 7;
  localparam int EXP_LAT = 278;
`else
  localparam int LEN     = 6;
  localparam int EXP_LAT = 277;
`endif

  logic       CLK;
  logic       RST;
  logic       SCIN_COINC;
  logic [1:0] CHIP_SEL;
  logic [7:0] CHIP_DATA;
  logic       DATA_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       BUSY;
  logic [7:0] EVT_COUNT;
  logic [7:0] DROP_COUNT;
  logic [3:0] MISS_FLAGS;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] chip_vals [4];
  logic [3:0] dr_en;
  logic       rdy;
  logic       tog_mode;
  logic       tog;

  logic [7:0] rx_q [$];
  int         stall_err  = 0;
  int         stall_seen = 0;
  logic       prev_stall;
  logic [7:0] prev_data;

  tube_readout_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .SCIN_COINC (SCIN_COINC),
    .CHIP_SEL   (CHIP_SEL),
    .CHIP_DATA  (CHIP_DATA),
    .DATA_READY (DATA_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .BUSY       (BUSY),
    .EVT_COUNT  (EVT_COUNT),
    .DROP_COUNT (DROP_COUNT),
    .MISS_FLAGS (MISS_FLAGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign CHIP_DATA  = chip_vals[CHIP_SEL];
  assign DATA_READY = dr_en[CHIP_SEL];
  assign OUT_READY  = tog_mode ? tog : rdy;

  initial tog = 1'b0;
  always @(posedge CLK) begin
    #1;
    tog = ~tog;
  end

  initial prev_stall = 1'b0;
  initial prev_data  = 8'h00;
  always @(negedge CLK) begin
    if (!RST) begin
      if (OUT_VALID && OUT_READY) rx_q.push_back(OUT_DATA);
      if (prev_stall && (!OUT_VALID || OUT_DATA !== prev_data)) stall_err++;
      if (OUT_VALID && !OUT_READY) stall_seen++;
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic string fmt_q();
    string s;
    s = "";
    foreach (rx_q[i]) s = {s, $sformatf("%h ", rx_q[i])};
    return s;
  endfunction

  // Pulses a trigger and waits for the frame to complete; lat = edges from trigger edge to final accept.
  task automatic run_event(output int lat, output logic busy1, output logic ok);
    logic [7:0] e0;
    e0    = EVT_COUNT;
    ok    = 1'b0;
    lat   = -1;
    busy1 = 1'b0;
    @(posedge CLK); #1;
    SCIN_COINC = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK); #1;
      if (n == 0) begin
        SCIN_COINC = 1'b0;
        busy1      = BUSY;
      end
      if (EVT_COUNT !== e0) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total_cnt++;
    if ({CHIP_SEL, OUT_DATA, OUT_VALID, BUSY, EVT_COUNT, DROP_COUNT, MISS_FLAGS} !== 34'd0)
      $display("[TB] FAIL reset_outputs got %h required 0",
               {CHIP_SEL, OUT_DATA, OUT_VALID, BUSY, EVT_COUNT, DROP_COUNT, MISS_FLAGS});
    else pass_cnt++;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_single;
    logic [7:0] exp [$];
    int lat; logic busy1, ok, good;
    exp = '{8'hA5, 8'h00, 8'h04, 8'h10, 8'h22, 8'h7F};
`ifdef TUBE_READOUT_CSUM_EN
    exp.push_back(8'h49);
`endif
    rx_q.delete();
    run_event(lat, busy1, ok);
    total_cnt++;
    if (!ok) $display("[TB] FAIL single_done timeout waiting for frame");
    else pass_cnt++;
    total_cnt++;
    if (busy1 !== 1'b1) $display("[TB] FAIL single_busy_rise got %b required 1", busy1);
    else pass_cnt++;
    total_cnt++;
    if (lat != EXP_LAT) $display("[TB] FAIL single_latency got %0d required %0d", lat, EXP_LAT);
    else pass_cnt++;
    good = (rx_q.size() == exp.size());
    for (int i = 0; i < exp.size() && good; i++) if (rx_q[i] !== exp[i]) good = 1'b0;
    total_cnt++;
    if (!good) $display("[TB] FAIL single_frame got %s", fmt_q());
    else pass_cnt++;
    total_cnt++;
    if ({EVT_COUNT, MISS_FLAGS, BUSY, OUT_VALID} !== {8'd1, 4'b0000, 1'b0, 1'b0})
      $display("[TB] FAIL single_status got evt=%0d miss=%b busy=%b valid=%b required 1/0000/0/0",
               EVT_COUNT, MISS_FLAGS, BUSY, OUT_VALID);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [$];
    int lat, se0, ss0; logic busy1, ok, good;
    exp = '{8'hA5, 8'h01, 8'h04, 8'h10, 8'h22, 8'h7F};
`ifdef TUBE_READOUT_CSUM_EN
    exp.push_back(8'h48);
`endif
    rx_q.delete();
    se0 = stall_err;
    ss0 = stall_seen;
    tog_mode = 1'b1;
    run_event(lat, busy1, ok);
    tog_mode = 1'b0;
    good = ok && (rx_q.size() == exp.size());
    for (int i = 0; i < exp.size() && good; i++) if (rx_q[i] !== exp[i]) good = 1'b0;
    total_cnt++;
    if (!good) $display("[TB] FAIL bp_frame got %s", fmt_q());
    else pass_cnt++;
    total_cnt++;
    if (stall_err != se0 || stall_seen == ss0)
      $display("[TB] FAIL bp_hold got violations=%0d stalls=%0d required 0 violations and >0 stalls",
               stall_err - se0, stall_seen - ss0);
    else pass_cnt++;
    total_cnt++;
    if (EVT_COUNT !== 8'd2) $display("[TB] FAIL bp_evt got %0d required 2", EVT_COUNT);
    else pass_cnt++;
  endtask

  task automatic test_missing;
    logic [7:0] exp [$];
    int lat; logic busy1, ok, good;
    exp = '{8'hA5, 8'h02, 8'h04, 8'h10, 8'hFF, 8'h7F};
`ifdef TUBE_READOUT_CSUM_EN
    exp.push_back(8'h96);
`endif
    rx_q.delete();
    dr_en = 4'b1011;
    run_event(lat, busy1, ok);
    dr_en = 4'b1111;
    good = ok && (rx_q.size() == exp.size());
    for (int i = 0; i < exp.size() && good; i++) if (rx_q[i] !== exp[i]) good = 1'b0;
    total_cnt++;
    if (!good) $display("[TB] FAIL miss_frame got %s", fmt_q());
    else pass_cnt++;
    total_cnt++;
    if (MISS_FLAGS !== 4'b0100) $display("[TB] FAIL miss_flags got %b required 0100", MISS_FLAGS);
    else pass_cnt++;
    total_cnt++;
    if (EVT_COUNT !== 8'd3) $display("[TB] FAIL miss_evt got %0d required 3", EVT_COUNT);
    else pass_cnt++;
  endtask

  task automatic test_retrigger;
    logic done_ok;
    rx_q.delete();
    @(posedge CLK); #1; SCIN_COINC = 1'b1;
    @(posedge CLK); #1; SCIN_COINC = 1'b0;
    total_cnt++;
    if (MISS_FLAGS !== 4'b0000) $display("[TB] FAIL retrig_miss_clear got %b required 0000", MISS_FLAGS);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      repeat (10) @(posedge CLK);
      #1; SCIN_COINC = 1'b1;
      @(posedge CLK); #1; SCIN_COINC = 1'b0;
    end
    done_ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK); #1;
      if (EVT_COUNT === 8'd4) begin done_ok = 1'b1; break; end
    end
    repeat (50) @(posedge CLK);
    #1;
    total_cnt++;
    if (DROP_COUNT !== 8'd3) $display("[TB] FAIL retrig_drop got %0d required 3", DROP_COUNT);
    else pass_cnt++;
    total_cnt++;
    if (!done_ok || rx_q.size() != LEN || BUSY !== 1'b0)
      $display("[TB] FAIL retrig_frames got done=%b bytes=%0d busy=%b required 1/%0d/0",
               done_ok, rx_q.size(), BUSY, LEN);
    else pass_cnt++;

    // Stall the sink so the event stays busy for all 300 extra edges.
    rdy = 1'b0;
    @(posedge CLK); #1; SCIN_COINC = 1'b1;
    @(posedge CLK); #1; SCIN_COINC = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK); #1; SCIN_COINC = 1'b1;
      @(posedge CLK); #1; SCIN_COINC = 1'b0;
    end
    rdy = 1'b1;
    done_ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge CLK); #1;
      if (EVT_COUNT === 8'd5) begin done_ok = 1'b1; break; end
    end
    total_cnt++;
    if (!done_ok || DROP_COUNT !== 8'd255)
      $display("[TB] FAIL drop_saturate got done=%b drop=%0d required 1/255", done_ok, DROP_COUNT);
    else pass_cnt++;
  endtask

  task automatic test_wrap_reset;
    int lat, guard; logic busy1, ok, all_ok;
    all_ok = 1'b1;
    guard  = 0;
    while (EVT_COUNT !== 8'd255 && guard < 260) begin
      run_event(lat, busy1, ok);
      if (!ok) all_ok = 1'b0;
      guard++;
    end
    rx_q.delete();
    run_event(lat, busy1, ok);
    total_cnt++;
    if (!all_ok || !ok || rx_q.size() != LEN || rx_q[1] !== 8'hFF || EVT_COUNT !== 8'd0)
      $display("[TB] FAIL wrap_seq got ok=%b bytes=%s evt=%0d required seq FF evt 0",
               all_ok && ok, fmt_q(), EVT_COUNT);
    else pass_cnt++;

    rx_q.delete();
    @(posedge CLK); #1; SCIN_COINC = 1'b1;
    @(posedge CLK); #1; SCIN_COINC = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge CLK); #1;
      if (rx_q.size() >= 3) begin ok = 1'b1; break; end
    end
    RST = 1'b1;
    #2;
    total_cnt++;
    if (!ok || {CHIP_SEL, OUT_DATA, OUT_VALID, BUSY, EVT_COUNT, DROP_COUNT, MISS_FLAGS} !== 34'd0)
      $display("[TB] FAIL midframe_reset got reached=%b outputs=%h required 1/0", ok,
               {CHIP_SEL, OUT_DATA, OUT_VALID, BUSY, EVT_COUNT, DROP_COUNT, MISS_FLAGS});
    else pass_cnt++;
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    repeat (400) @(posedge CLK);
    #1;
    total_cnt++;
    if (rx_q.size() != 3 || BUSY !== 1'b0 || EVT_COUNT !== 8'd0)
      $display("[TB] FAIL midframe_quiet got bytes=%0d busy=%b evt=%0d required 3/0/0",
               rx_q.size(), BUSY, EVT_COUNT);
    else pass_cnt++;
  endtask

  task automatic test_level_trigger;
    logic done_ok;
    @(posedge CLK); #1;
    SCIN_COINC = 1'b1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    total_cnt++;
    if (BUSY !== 1'b0) $display("[TB] FAIL level_no_trigger got busy=%b required 0", BUSY);
    else pass_cnt++;
    SCIN_COINC = 1'b0;
    @(posedge CLK); #1; SCIN_COINC = 1'b1;
    @(posedge CLK); #1;
    total_cnt++;
    if (BUSY !== 1'b1) $display("[TB] FAIL level_retrigger got busy=%b required 1", BUSY);
    else pass_cnt++;
    SCIN_COINC = 1'b0;
    rx_q.delete();
    done_ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK); #1;
      if (EVT_COUNT === 8'd1) begin done_ok = 1'b1; break; end
    end
    total_cnt++;
    if (!done_ok || rx_q.size() != LEN || rx_q[1] !== 8'h00)
      $display("[TB] FAIL level_frame got done=%b bytes=%s required seq 00", done_ok, fmt_q());
    else pass_cnt++;
  endtask

  initial begin
    RST        = 1'b1;
    SCIN_COINC = 1'b0;
    rdy        = 1'b1;
    tog_mode   = 1'b0;
    dr_en      = 4'b1111;
    chip_vals  = '{8'h04, 8'h10, 8'h22, 8'h7F};
    test_reset();
    test_single();
    test_backpressure();
    test_missing();
    test_retrigger();
    test_wrap_reset();
    test_level_trigger();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
